// File: rtl/shift_seq_pkg.sv
// Shared FSM state encoding and shift-direction constants for shift_seq_ctrl.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam logic DIR_MSB = 1'b1;
  localparam logic DIR_LSB = 1'b0;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Transfer request/response bundle for shift_seq_ctrl.
// The rot signal exists only when SHIFT_ROTATE_EN is defined.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH) + 1
);
  logic             start;
  logic             dir;
  logic [CW-1:0]    len;
  logic [WIDTH-1:0] load_data;
  logic             ser_in;
`ifdef SHIFT_ROTATE_EN
  logic             rot;
`endif
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             busy;
  logic             done;

`ifdef SHIFT_ROTATE_EN
  modport master (
    output start, dir, len, load_data, ser_in, rot,
    input  q, ser_out, busy, done
  );
  modport slave (
    input  start, dir, len, load_data, ser_in, rot,
    output q, ser_out, busy, done
  );
`else
  modport master (
    output start, dir, len, load_data, ser_in,
    input  q, ser_out, busy, done
  );
  modport slave (
    input  start, dir, len, load_data, ser_in,
    output q, ser_out, busy, done
  );
`endif

endinterface

// File: rtl/shift_seq_ctrl_core.sv
// shift_core: WIDTH-bit bidirectional shift register with parallel load
// and a registered copy of the bit shifted out.
module shift_core
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_shift_en,
  input  logic             i_dir,
  input  logic             i_ser_in,
  output logic [WIDTH-1:0] o_q,
  output logic             o_ser_out
);

  logic [WIDTH-1:0] r_q;
  logic             r_ser_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q       <= '0;
      r_ser_out <= 1'b0;
    end else if (i_load) begin
      r_q <= i_load_data;
    end else if (i_shift_en) begin
      if (i_dir == DIR_MSB) begin
        r_q       <= {r_q[WIDTH-2:0], i_ser_in};
        r_ser_out <= r_q[WIDTH-1];
      end else begin
        r_q       <= {i_ser_in, r_q[WIDTH-1:1]};
        r_ser_out <= r_q[0];
      end
    end
  end

  assign o_q       = r_q;
  assign o_ser_out = r_ser_out;

endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences a counted serial shift of a loaded word.
// Optional circular shifting via the SHIFT_ROTATE_EN macro.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  shift_seq_ctrl_if.slave  bus
);

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_cnt;
  logic             r_dir;
  logic [CW-1:0]    w_len_sat;
  logic             w_load;
  logic             w_shift_en;
  logic             w_ser_bit;
  logic [WIDTH-1:0] w_q;
  logic             w_ser_out;

  // Requests longer than the register saturate so the count cannot wrap.
  assign w_len_sat = (bus.len > CW'(WIDTH)) ? CW'(WIDTH) : bus.len;

`ifdef SHIFT_ROTATE_EN
  logic r_rot;
  logic w_out_bit;

  assign w_out_bit = (r_dir == DIR_MSB) ? w_q[WIDTH-1] : w_q[0];
  assign w_ser_bit = r_rot ? w_out_bit : bus.ser_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rot <= 1'b0;
    end else if (w_load) begin
      r_rot <= bus.rot;
    end
  end
`else
  assign w_ser_bit = bus.ser_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next_state = (w_len_sat != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (r_cnt <= CW'(1)) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load     = 1'b0;
    w_shift_en = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    unique case (r_state)
      ST_IDLE:  w_load = bus.start;
      ST_SHIFT: begin
        w_shift_en = 1'b1;
        bus.busy   = 1'b1;
      end
      ST_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_dir <= 1'b0;
    end else if (w_load) begin
      r_cnt <= w_len_sat;
      r_dir <= bus.dir;
    end else if (w_shift_en) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_data (bus.load_data),
    .i_shift_en  (w_shift_en),
    .i_dir       (r_dir),
    .i_ser_in    (w_ser_bit),
    .o_q         (w_q),
    .o_ser_out   (w_ser_out)
  );

  assign bus.q       = w_q;
  assign bus.ser_out = w_ser_out;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl at WIDTH=4 with hand-computed expectations.
// Define SHIFT_ROTATE_EN to also exercise the rotate path.
module tb_shift_seq_ctrl;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  shift_seq_ctrl_if #(.WIDTH(4), .CW(3)) bus ();

  shift_seq_ctrl #(
    .WIDTH (4),
    .CW    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk          = 0;
    n_pass         = 0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.dir        = 1'b0;
    bus.len        = '0;
    bus.load_data  = '0;
    bus.ser_in     = 1'b0;
`ifdef SHIFT_ROTATE_EN
    bus.rot        = 1'b0;
`endif
    #12;
    chk("rst_q",       8'(bus.q),   8'h0);
    chk("rst_ser_out", 8'(bus.ser_out), 8'h0);
    chk("rst_busy",    8'(bus.busy), 8'h0);
    chk("rst_done",    8'(bus.done), 8'h0);
    rst = 1'b0;
    tick();

    // load 1011, dir=0, len=2, ser_in=1
    bus.load_data = 4'b1011; bus.dir = 1'b0; bus.len = 3'd2; bus.ser_in = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t1_load_q",    8'(bus.q), 8'b1011);
    chk("t1_load_busy", 8'(bus.busy), 8'h1);
    chk("t1_load_done", 8'(bus.done), 8'h0);
    tick();
    chk("t1_s1_q",    8'(bus.q), 8'b1101);
    chk("t1_s1_done", 8'(bus.done), 8'h0);
    tick();
    chk("t1_s2_q",    8'(bus.q), 8'b1110);
    chk("t1_s2_sout", 8'(bus.ser_out), 8'h1);
    chk("t1_s2_done", 8'(bus.done), 8'h1);
    tick();
    chk("t1_idle_done", 8'(bus.done), 8'h0);
    chk("t1_idle_busy", 8'(bus.busy), 8'h0);
    chk("t1_idle_q",    8'(bus.q), 8'b1110);

    // load 0001, dir=1, len=4, ser_in=0
    bus.load_data = 4'b0001; bus.dir = 1'b1; bus.len = 3'd4; bus.ser_in = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t2_load_q", 8'(bus.q), 8'b0001);
    tick();
    chk("t2_s1_q", 8'(bus.q), 8'b0010);
    chk("t2_s1_done", 8'(bus.done), 8'h0);
    tick();
    chk("t2_s2_q", 8'(bus.q), 8'b0100);
    chk("t2_s2_done", 8'(bus.done), 8'h0);
    tick();
    chk("t2_s3_q", 8'(bus.q), 8'b1000);
    chk("t2_s3_sout", 8'(bus.ser_out), 8'h0);
    chk("t2_s3_done", 8'(bus.done), 8'h0);
    tick();
    chk("t2_s4_q", 8'(bus.q), 8'b0000);
    chk("t2_s4_sout", 8'(bus.ser_out), 8'h1);
    chk("t2_s4_done", 8'(bus.done), 8'h1);
    tick();
    chk("t2_after_done", 8'(bus.done), 8'h0);
    chk("t2_after_sout", 8'(bus.ser_out), 8'h1);

    // len=0: straight to DONE, no shift
    bus.load_data = 4'b0110; bus.len = 3'd0; bus.ser_in = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t3_q",    8'(bus.q), 8'b0110);
    chk("t3_done", 8'(bus.done), 8'h1);
    chk("t3_busy", 8'(bus.busy), 8'h1);
    tick();
    chk("t3_q_hold", 8'(bus.q), 8'b0110);
    chk("t3_done_end", 8'(bus.done), 8'h0);

    // len=7 saturates to 4; start held high while busy; dir/len/ser_in disturbed mid-transfer
    bus.load_data = 4'b1010; bus.dir = 1'b0; bus.len = 3'd7; bus.ser_in = 1'b0; bus.start = 1'b1;
    tick();
    chk("t4_load_q", 8'(bus.q), 8'b1010);
    bus.dir = 1'b1; bus.len = 3'd1; bus.load_data = 4'b1111;
    tick();
    chk("t4_s1_q", 8'(bus.q), 8'b0101);
    chk("t4_s1_done", 8'(bus.done), 8'h0);
    tick();
    chk("t4_s2_q", 8'(bus.q), 8'b0010);
    chk("t4_s2_done", 8'(bus.done), 8'h0);
    bus.ser_in = 1'b1;
    tick();
    chk("t4_s3_q", 8'(bus.q), 8'b1001);
    chk("t4_s3_done", 8'(bus.done), 8'h0);
    tick();
    chk("t4_s4_q", 8'(bus.q), 8'b1100);
    chk("t4_s4_sout", 8'(bus.ser_out), 8'h1);
    chk("t4_s4_done", 8'(bus.done), 8'h1);
    bus.start = 1'b0;
    tick();
    chk("t4_idle_q", 8'(bus.q), 8'b1100);
    chk("t4_idle_done", 8'(bus.done), 8'h0);
    chk("t4_idle_busy", 8'(bus.busy), 8'h0);
    tick();
    chk("t4_idle2_busy", 8'(bus.busy), 8'h0);

    // asynchronous reset mid-SHIFT
    bus.load_data = 4'b1111; bus.dir = 1'b1; bus.len = 3'd3; bus.ser_in = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("t5_pre_busy", 8'(bus.busy), 8'h1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_q",    8'(bus.q), 8'h0);
    chk("t5_rst_busy", 8'(bus.busy), 8'h0);
    chk("t5_rst_done", 8'(bus.done), 8'h0);
    chk("t5_rst_sout", 8'(bus.ser_out), 8'h0);
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_done", 8'(bus.done), 8'h0);
    end
    chk("t5_q_idle", 8'(bus.q), 8'h0);

`ifdef SHIFT_ROTATE_EN
    // rotate: outgoing MSB re-enters at bit 0
    bus.load_data = 4'b1000; bus.dir = 1'b1; bus.len = 3'd1; bus.ser_in = 1'b0; bus.rot = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.rot   = 1'b0;
    chk("t6_load_q", 8'(bus.q), 8'b1000);
    tick();
    chk("t6_rot_q",    8'(bus.q), 8'b0001);
    chk("t6_rot_sout", 8'(bus.ser_out), 8'h1);
    chk("t6_rot_done", 8'(bus.done), 8'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
